// File: rtl/axis_conv_pkg.sv
// axis_conv_pkg: shared TUSER bit indices and default widths for the conv output path
package axis_conv_pkg;
    localparam int CORES_DEF       = 32;
    localparam int UNITS_DEF       = 8;
    localparam int WORD_WIDTH_DEF  = 25;
    localparam int TUSER_WIDTH_DEF = 8;
    localparam int DEPTH_DEF       = 4;
    localparam int I_IS_NOT_MAX      = 0;
    localparam int I_IS_MAX          = 1;
    localparam int I_IS_1X1          = 2;
    localparam int I_IS_LRELU        = 3;
    localparam int I_IS_TOP_BLOCK    = 4;
    localparam int I_IS_BOTTOM_BLOCK = 5;
    localparam int I_KERNEL_W_1      = 6;
endpackage

// File: rtl/axis_conv_fifo_core.sv
// axis_conv_fifo_core: storage array with wrapping read/write pointers
// clk_i/rst_i: clock, sync active-high reset (pointers only; storage is never reset)
// push_i/wdata_i: write one entry at the tail; pop_i: retire the head
// rdata_o: head entry, read combinationally
module axis_conv_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/axis_conv_out_buffer.sv
// axis_conv_out_buffer: registered-ready output FIFO that serialises each result beat into LANES sub-beats
// s_axis_*: full result beats in; s_axis_tready is registered and also serves as the engine clock enable
// m_axis_*: one lane per handshake, lowest lane first; tuser repeated, tlast on the final lane only
// level: current entry count
// Optional AXIS_CONV_OUT_STATS_EN adds beats_out (pops, wraps at 2^32) and max_level (peak level)
module axis_conv_out_buffer
    import axis_conv_pkg::*;
#(
    parameter int CORES       = CORES_DEF,
    parameter int UNITS       = UNITS_DEF,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
    parameter int TUSER_WIDTH = TUSER_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SLACK       = 1,
    parameter int LANES       = 1
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [WORD_WIDTH*CORES*UNITS-1:0]         s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                    s_axis_tuser,
    input  logic                                      s_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [WORD_WIDTH*CORES*UNITS/LANES-1:0]   m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                    m_axis_tuser,
    output logic                                      m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0]                level
`ifdef AXIS_CONV_OUT_STATS_EN
    ,
    output logic [31:0]                               beats_out,
    output logic [$clog2(DEPTH+1)-1:0]                max_level
`endif
);
    localparam int BW = WORD_WIDTH*CORES*UNITS;
    localparam int LD = BW/LANES;
    localparam int EW = BW+TUSER_WIDTH+1;
    localparam int LW = $clog2(DEPTH+1);
    logic [LW-1:0]          level_q, level_d;
    logic                   tready_q, tready_d;
    logic                   push, pop, last_lane;
    logic [EW-1:0]          head;
    logic [BW-1:0]          head_data;
    logic [TUSER_WIDTH-1:0] head_user;
    logic                   head_last;
    assign push          = s_axis_tvalid & tready_q;
    assign m_axis_tvalid = level_q != '0;
    assign pop           = m_axis_tvalid & m_axis_tready & last_lane;
    // Ready looks at the post-edge occupancy so a registered ready can never admit a push into a full FIFO.
    always_comb begin
        level_d  = level_q + LW'(push) - LW'(pop);
        tready_d = level_d <= LW'(DEPTH-1-SLACK);
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            level_q  <= '0;
            tready_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            tready_q <= tready_d;
        end
    end
    axis_conv_fifo_core #(.WIDTH(EW), .DEPTH(DEPTH)) u_core (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({s_axis_tdata, s_axis_tuser, s_axis_tlast}),
        .rdata_o (head)
    );
    assign {head_data, head_user, head_last} = head;
    generate
        if (LANES == 1) begin : g_single
            assign last_lane    = 1'b1;
            assign m_axis_tdata = head_data;
        end else begin : g_lanes
            localparam int IW = $clog2(LANES);
            logic [IW-1:0]            lane_idx_q, lane_idx_d;
            logic [LANES-1:0][LD-1:0] lanes;
            assign lanes        = head_data;
            assign last_lane    = lane_idx_q == IW'(LANES-1);
            assign m_axis_tdata = lanes[lane_idx_q];
            always_comb begin
                lane_idx_d = lane_idx_q;
                if (m_axis_tvalid & m_axis_tready) lane_idx_d = last_lane ? '0 : lane_idx_q + 1'b1;
            end
            always_ff @(posedge aclk) begin
                if (areset) lane_idx_q <= '0;
                else        lane_idx_q <= lane_idx_d;
            end
        end
    endgenerate
    assign m_axis_tuser  = head_user;
    assign m_axis_tlast  = head_last & last_lane;
    assign s_axis_tready = tready_q;
    assign level         = level_q;
`ifdef AXIS_CONV_OUT_STATS_EN
    logic [31:0]   beats_q;
    logic [LW-1:0] max_q;
    always_ff @(posedge aclk) begin
        if (areset) begin
            beats_q <= '0;
            max_q   <= '0;
        end else begin
            if (pop)             beats_q <= beats_q + 1'b1;
            if (level_q > max_q) max_q   <= level_q;
        end
    end
    assign beats_out = beats_q;
    assign max_level = max_q;
`endif
endmodule

// File: tb/tb_axis_conv_out_buffer.sv
// tb_axis_conv_out_buffer: directed checks of a LANES=1 and a LANES=4 instance sharing clock and reset
module tb_axis_conv_out_buffer;
    logic clk = 1'b0, areset;
    always #5 clk = ~clk;
    logic v1, r1, l1, mv1, mr1, ml1;
    logic [15:0] d1, md1;
    logic [7:0] u1, mu1;
    logic [2:0] lvl1;
    logic v4, r4, l4, mv4, mr4, ml4;
    logic [15:0] d4;
    logic [3:0] md4;
    logic [7:0] u4, mu4;
    logic [2:0] lvl4;
`ifdef AXIS_CONV_OUT_STATS_EN
    logic [31:0] bo1, bo4;
    logic [2:0] mx1, mx4;
`endif
    axis_conv_out_buffer #(.CORES(2), .UNITS(2), .WORD_WIDTH(4), .TUSER_WIDTH(8), .DEPTH(4), .SLACK(1), .LANES(1)) dut1 (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(v1), .s_axis_tready(r1), .s_axis_tdata(d1), .s_axis_tuser(u1), .s_axis_tlast(l1),
        .m_axis_tvalid(mv1), .m_axis_tready(mr1), .m_axis_tdata(md1), .m_axis_tuser(mu1), .m_axis_tlast(ml1),
        .level(lvl1)
`ifdef AXIS_CONV_OUT_STATS_EN
        , .beats_out(bo1), .max_level(mx1)
`endif
    );
    axis_conv_out_buffer #(.CORES(2), .UNITS(2), .WORD_WIDTH(4), .TUSER_WIDTH(8), .DEPTH(4), .SLACK(1), .LANES(4)) dut4 (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(v4), .s_axis_tready(r4), .s_axis_tdata(d4), .s_axis_tuser(u4), .s_axis_tlast(l4),
        .m_axis_tvalid(mv4), .m_axis_tready(mr4), .m_axis_tdata(md4), .m_axis_tuser(mu4), .m_axis_tlast(ml4),
        .level(lvl4)
`ifdef AXIS_CONV_OUT_STATS_EN
        , .beats_out(bo4), .max_level(mx4)
`endif
    );
    int n_assert = 0, n_fail = 0;
    int acc, sent, recv, cyc;
    logic [15:0] lanes_exp, prev_d, tmp;
    logic [7:0] prev_u;
    logic prev_stall;
    logic [15:0] sb[$];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        areset = 1'b1;
        {v1, l1, mr1, v4, l4, mr4} = '0;
        d1 = '0; u1 = '0; d4 = '0; u4 = '0;
        repeat (2) @(negedge clk);
        check("rst_level", 32'(lvl1), 0);
        check("rst_tready", 32'(r1), 0);
        check("rst_mvalid", 32'(mv1), 0);
        check("rst_tready4", 32'(r4), 0);
        areset = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 32'(r1), 1);
        check("tready_after_rst4", 32'(r4), 1);
        // fill with downstream stalled: exactly DEPTH-SLACK beats accepted
        v1 = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            d1 = 16'(16'h1000 + acc);
            u1 = 8'(acc + 8'h40);
            if (r1) acc++;
            @(negedge clk);
        end
        v1 = 1'b0;
        check("fill_accepted", 32'(acc), 3);
        check("fill_tready", 32'(r1), 0);
        check("fill_level", 32'(lvl1), 3);
        mr1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_mvalid", 32'(mv1), 1);
            check("drain_data", 32'(md1), 32'(16'h1000 + i));
            check("drain_user", 32'(mu1), 32'(8'h40 + i));
            @(negedge clk);
        end
        check("drain_empty", 32'(mv1), 0);
        check("drain_tready", 32'(r1), 1);
        // streaming with both sides ready: latency 1, level never above 1
        for (int c = 0; c <= 100; c++) begin
            if (c == 0) check("stream_lat0", 32'(mv1), 0);
            else begin
                check("stream_mvalid", 32'(mv1), 1);
                check("stream_data", 32'(md1), 32'(c - 1));
            end
            check("stream_level_le1", 32'(lvl1 <= 3'd1), 1);
            check("stream_tready", 32'(r1), 1);
            v1 = c < 100;
            d1 = 16'(c);
            @(negedge clk);
        end
        check("stream_end_empty", 32'(mv1), 0);
        mr1 = 1'b0;
        // LANES=4: one entry, tlast=1, tuser=0x5A, with a one-cycle stall on lane 1
        lanes_exp = 16'hDCBA;
        v4 = 1'b1; d4 = lanes_exp; u4 = 8'h5A; l4 = 1'b1; mr4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("lane_mvalid", 32'(mv4), 1);
            check("lane_data", 32'(md4), 32'(lanes_exp[k*4 +: 4]));
            check("lane_user", 32'(mu4), 32'h5A);
            check("lane_last", 32'(ml4), 32'(k == 3));
            if (k == 1) begin
                mr4 = 1'b0;
                @(negedge clk);
                check("stall_data", 32'(md4), 32'hB);
                check("stall_user", 32'(mu4), 32'h5A);
                check("stall_last", 32'(ml4), 0);
                mr4 = 1'b1;
            end
            @(negedge clk);
        end
        check("lane_done", 32'(mv4), 0);
        lanes_exp = 16'h4321;
        v4 = 1'b1; d4 = lanes_exp; u4 = 8'h33; l4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("nolast_data", 32'(md4), 32'(lanes_exp[k*4 +: 4]));
            check("nolast_last", 32'(ml4), 0);
            @(negedge clk);
        end
        mr4 = 1'b0;
        // random traffic with scoreboard and stall-stability check
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            if (mv1) begin
                check("rnd_data", 32'(md1), sb.size() != 0 ? 32'(sb[0]) : 32'hDEAD0000);
                check("rnd_user", 32'(mu1), sb.size() != 0 ? 32'(sb[0][7:0] ^ 8'h3C) : 32'hDEAD0000);
                if (prev_stall) check("rnd_hold", 32'({md1, mu1}), 32'({prev_d, prev_u}));
            end else check("rnd_empty", 32'(sb.size()), 0);
            mr1 = 1'($urandom_range(0, 1));
            v1 = sent < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
            d1 = 16'($urandom);
            u1 = d1[7:0] ^ 8'h3C;
            if (v1 && r1) begin
                sb.push_back(d1);
                sent++;
            end
            if (mv1 && mr1 && sb.size() != 0) begin
                tmp = sb.pop_front();
                recv++;
            end
            prev_stall = mv1 && !mr1;
            prev_d = md1;
            prev_u = mu1;
            @(negedge clk);
            cyc++;
        end
        check("rnd_received", 32'(recv), 1000);
        v1 = 1'b0; mr1 = 1'b0;
        @(negedge clk);
        check("rnd_drained", 32'(lvl1), 0);
        // reset mid-serialisation with two entries held
        v4 = 1'b1; d4 = 16'h8765; u4 = 8'h11; l4 = 1'b0; mr4 = 1'b0;
        @(negedge clk);
        d4 = 16'hFEDC; u4 = 8'h22;
        @(negedge clk);
        v4 = 1'b0; mr4 = 1'b1;
        check("mid_level", 32'(lvl4), 2);
        @(negedge clk);
        check("mid_level_lane1", 32'(lvl4), 2);
        check("mid_lane1_data", 32'(md4), 32'h6);
        mr4 = 1'b0; areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check("rst_mid_level", 32'(lvl4), 0);
        check("rst_mid_mvalid", 32'(mv4), 0);
        check("rst_mid_tready", 32'(r4), 0);
        @(negedge clk);
        check("rst_mid_tready_next", 32'(r4), 1);
        check("rst_mid_level_next", 32'(lvl4), 0);
        v4 = 1'b1; d4 = 16'h3CB7; mr4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        check("post_rst_mvalid", 32'(mv4), 1);
        check("post_rst_lane0", 32'(md4), 32'h7);
        check("post_rst_level", 32'(lvl4), 1);
        repeat (4) @(negedge clk);
        check("post_rst_empty", 32'(mv4), 0);
        mr4 = 1'b0;
`ifdef AXIS_CONV_OUT_STATS_EN
        check("stats_rst_beats", bo1, 0);
        check("stats_rst_max", 32'(mx1), 0);
`endif
        // seven entries with peak occupancy 3
        v1 = 1'b1;
        repeat (4) @(negedge clk);
        v1 = 1'b0;
        check("stats_peak_level", 32'(lvl1), 3);
        mr1 = 1'b1;
        repeat (3) @(negedge clk);
        check("stats_first_drain", 32'(lvl1), 0);
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            @(negedge clk);
            v1 = 1'b0;
            @(negedge clk);
        end
        check("stats_final_level", 32'(lvl1), 0);
`ifdef AXIS_CONV_OUT_STATS_EN
        check("stats_beats_out", bo1, 7);
        check("stats_max_level", 32'(mx1), 3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_conv_out_buffer.md
AXIS_CONV_OUT_BUFFER -- requirements
Module: axis_conv_out_buffer

Interface
REQ-001 SHALL have parameter CORES, default 32, number of cores per beat.
REQ-002 SHALL have parameter UNITS, default 8, number of units per core.
REQ-003 SHALL have parameter WORD_WIDTH, default 25, bits per accumulator word.
REQ-004 SHALL have parameter TUSER_WIDTH, default 8, sideband width.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries; power of 2, at least 2.
REQ-006 SHALL have parameter SLACK, default 1, early-deassert headroom; range 0 to DEPTH-1.
REQ-007 SHALL have parameter LANES, default 1, output serialisation factor; divides CORES*UNITS.
REQ-008 SHALL have port aclk, input, 1, sole clock; one clock domain.
REQ-009 SHALL have port areset, input, 1, reset; synchronous and active-high.
REQ-010 SHALL have port s_axis_tvalid, input, 1, input beat valid.
REQ-011 SHALL have port s_axis_tready, output, 1, registered ready; doubles as the engine clken.
REQ-012 SHALL have port s_axis_tdata, input, WORD_WIDTH*CORES*UNITS, full result beat.
REQ-013 SHALL have ports s_axis_tuser (input, TUSER_WIDTH) and s_axis_tlast (input, 1).
REQ-014 SHALL have port m_axis_tvalid, output, 1, output valid.
REQ-015 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-016 SHALL have port m_axis_tdata, output, WORD_WIDTH*CORES*UNITS/LANES, one lane.
REQ-017 SHALL have ports m_axis_tuser (output, TUSER_WIDTH) and m_axis_tlast (output, 1).
REQ-018 SHALL have port level, output, $clog2(DEPTH+1), current entry count.

Function
REQ-019 SHALL push an entry only on s_axis_tvalid AND s_axis_tready; data, tuser and tlast are stored together.
REQ-020 SHALL compute next_level = level + push - pop, and register s_axis_tready = (next_level <= DEPTH-1-SLACK).
REQ-021 SHALL never push while full; REQ-020 guarantees this.
REQ-022 SHALL drive m_axis_tvalid = (level != 0), with output fields read combinationally from the head entry.
REQ-023 SHALL make a pushed beat visible on m_axis_tvalid one cycle after the push edge (latency 1).
REQ-024 SHALL keep a sub-beat index lane_idx in 0..LANES-1 and present lane lane_idx of the head entry, lowest lane first.
REQ-025 SHALL advance lane_idx on each m_axis_tvalid AND m_axis_tready; at LANES-1 it wraps to 0 and pops the head.
REQ-026 SHALL repeat m_axis_tuser on every sub-beat of an entry.
REQ-027 SHALL assert m_axis_tlast only on the final sub-beat of an entry stored with tlast=1.
REQ-028 SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-029 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-030 SHALL, when LANES=1, pop on every output handshake and carry no lane_idx state.
REQ-031 SHALL let both pointers wrap modulo DEPTH.

Reset
REQ-032 SHALL, while areset=1, hold level=0, both pointers=0, lane_idx=0, s_axis_tready=0 and m_axis_tvalid=0.
REQ-033 SHALL assert s_axis_tready in the first cycle after areset falls.
REQ-034 SHALL discard all entries on a reset mid-operation, including a partially serialised entry.
REQ-035 SHALL NOT reset the storage array.

Configuration
REQ-036 SHALL add, when macro AXIS_CONV_OUT_STATS_EN is defined, output beats_out (32 bits) and output max_level (width of level).
REQ-037 SHALL, with AXIS_CONV_OUT_STATS_EN: increment beats_out on every pop, wrapping at 2^32; raise max_level to track the highest level reached; clear both on reset.
REQ-038 SHALL, without AXIS_CONV_OUT_STATS_EN, omit both ports and their logic, with the remaining behaviour identical.

Structure
REQ-039 SHALL take the TUSER bit-index constants (I_IS_*, I_KERNEL_W_1) and the default width constants from shared package axis_conv_pkg.
REQ-040 SHALL place storage plus the read and write pointers in one sub-module, axis_conv_fifo_core; the top level holds the ready, lane and stats logic.

Verification
REQ-041 SHALL cover: DEPTH=4, SLACK=1, m_axis_tready=0, continuous valid -> exactly 3 beats accepted, s_axis_tready=0, level=3.
REQ-042 SHALL cover: LANES=4, one beat with tlast=1 and tuser=0x5A -> 4 output beats in lanes 0,1,2,3 order, tuser 0x5A on all, tlast only on beat 4.
REQ-043 SHALL cover: LANES=1, both sides always ready, 100 beats -> 100 outputs in order, level never above 1, one-cycle latency.
REQ-044 SHALL cover: random m_axis_tready at 50% for 1000 beats -> no loss, duplication or reorder, and output held stable during every stall.
REQ-045 SHALL cover: areset pulsed for 1 cycle with level=2 mid-serialisation -> level=0 and m_axis_tvalid=0 next cycle, s_axis_tready=1 the cycle after.
REQ-046 SHALL cover, with AXIS_CONV_OUT_STATS_EN: 7 entries pushed and popped with peak occupancy 3 -> beats_out=7, max_level=3.
